// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder that time-shares one 4-bit CLA cell, one nibble per cycle, LSB first.
// Define CLA_SEQ_SUB_EN to honour in_sub (A-B via ~B and carry-in 1); otherwise in_sub is ignored.

module Cla4Cell (
    output logic [3:0] o_sum,
    output logic       o_cout,
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Carries are flattened generate/propagate terms rather than a ripple chain.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign o_sum  = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];
endmodule

module cla_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;

    logic              w_accept;
    logic              w_lastNib;
    logic [WIDTH-1:0]  w_aShift;
    logic [WIDTH-1:0]  w_bShift;
    logic [3:0]        w_nibSum;
    logic              w_nibCout;

    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_lastNib = (r_idx == IDXW'(NIB - 1));
    assign w_aShift  = r_a >> {r_idx, 2'b00};
    assign w_bShift  = r_b >> {r_idx, 2'b00};

    Cla4Cell u_cell (
        .o_sum  (w_nibSum),
        .o_cout (w_nibCout),
        .i_a    (w_aShift[3:0]),
        .i_b    (w_bShift[3:0]),
        .i_cin  (r_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_nextState = RUN;
            RUN:     if (w_lastNib) w_nextState = DONE;
            DONE:    if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The sum register is cleared on accept, so each nibble can be OR-ed into place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_idx <= '0;
            r_a   <= in_a;
            r_sum <= '0;
`ifdef CLA_SEQ_SUB_EN
            r_b     <= in_sub ? ~in_b : in_b;
            r_carry <= in_sub ? 1'b1 : in_cin;
`else
            r_b     <= in_b;
            r_carry <= in_cin;
`endif
        end else if (r_state == RUN) begin
            r_sum   <= r_sum | (WIDTH'(w_nibSum) << {r_idx, 2'b00});
            r_carry <= w_nibCout;
            if (!w_lastNib) begin
                r_idx <= r_idx + IDXW'(1);
            end
        end
    end

`ifndef CLA_SEQ_SUB_EN
    logic w_unusedSub;
    assign w_unusedSub = in_sub;
`endif

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_carry;
endmodule

// File: doc/cla_nibble_sequencer.md
Name: cla_nibble_sequencer

Overview:
- Multi-cycle adder controller. Adds two WIDTH-bit operands by time-sharing one instance of the team's 4-bit cla cell. Port order of that cell: sum[3:0], carry out, a[3:0], b[3:0], carry in.
- Feeds the cell one nibble per cycle, least significant first. Carries the ripple between nibbles in a register.
- Sits between an operand producer and a result consumer. Both sides use valid/ready handshakes.

Parameters:
- WIDTH, 16, operand and sum width. Must be a multiple of 4 and at least 4. NIB = WIDTH/4.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry in
- in_sub  input  1  subtract request; used only when CLA_SEQ_SUB_EN is defined
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  final carry out
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, nibble index=0, carry reg=0, operand regs=0, sum reg=0.
  - in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0.
- Reset asserted mid-operation aborts immediately. Nothing of the partial result is retained or emitted.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_a, in_b and carry reg=in_cin; clear the sum reg; idx=0; go to RUN.
- State RUN:
  - in_ready=0.
  - Each cycle the cla cell adds a_reg[4*idx+:4], b_reg[4*idx+:4] and the carry reg.
  - The nibble sum is written to sum_reg[4*idx+:4]; the carry reg takes the cell's carry out.
  - If idx==NIB-1: go to DONE. Otherwise idx++.
- State DONE:
  - out_valid=1. out_sum=sum reg, out_cout=carry reg, both held stable.
  - On out_ready: go to IDLE next cycle, out_valid drops.
  - out_ready may be low indefinitely. Outputs stay frozen and in_valid is ignored meanwhile.
- Latency: accept edge at cycle k gives out_valid=1 after edge k+NIB. WIDTH=4 takes one RUN cycle.
- Throughput: one operation per NIB+2 cycles at best (IDLE, NIB×RUN, DONE). Input acceptance does not overlap the DONE-state handshake.
- out_valid/out_sum/out_cout are registered. No combinational path from in_* or out_ready to out_*.
- in_ready is a decode of state. out_ready has no combinational effect on in_ready in the same cycle.
- Arithmetic is modulo 2^WIDTH. out_cout is the carry out of bit WIDTH-1.
- Operand changes while in RUN/DONE have no effect.

Optional Feature:
- Macro: CLA_SEQ_SUB_EN.
- Defined:
  - in_sub is latched at acceptance.
  - If in_sub=1: b_reg=~in_b and carry reg=1 (in_cin ignored), giving A−B. out_cout=1 means no borrow.
- Not defined:
  - in_sub is ignored (port present, unused); always A+B+in_cin.

Test Plan:
- WIDTH=16, A=0x1234, B=0x0FFF, cin=0, out_ready=1 -> out_valid exactly 4 cycles after accept; sum=0x2233, cout=0; in_ready back to 1 the cycle after the out handshake.
- A=0xFFFF, B=0x0001, cin=0 -> sum=0x0000, cout=1 (carry propagates through all 4 nibble steps). Also A=0xFFFF, B=0x0000, cin=1 -> 0x0000, cout=1.
- Backpressure: A=0x00F0, B=0x0010; out_ready held low 5 cycles after out_valid -> sum=0x0100, cout=0 stable, out_valid high all 5 cycles; a new in_valid meanwhile is not accepted (in_ready=0).
- Reset mid-RUN: accept A=0xAAAA, B=0x5555, drop rst_n at the second RUN cycle -> all outputs 0 at once, state IDLE, out_valid never asserts for that operation; next op A=0x0001, B=0x0002 -> 0x0003, cout=0.
- CLA_SEQ_SUB_EN defined: A=0x0005, B=0x0007, in_sub=1, cin=0 -> sum=0xFFFE, cout=0. A=0x0007, B=0x0005 -> 0x0002, cout=1. Without macro, same stimulus -> 0x000C, cout=0.
- WIDTH=4: A=0x9, B=0x8 -> out_valid one cycle after accept, sum=0x1, cout=1.
